// File: rtl/tt_logic_pkg.sv
// Shared types and helpers for the truth-table logic evaluator.
package tt_logic_pkg;

   // Largest supported function: 6 inputs, 64-entry table.
   localparam int unsigned MAX_N_IN = 6;
   localparam int unsigned MAX_TT_W = 2 ** MAX_N_IN;

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StDrain = 2'd1,
      StLoad  = 2'd2
   } tt_state_e;

   // Bit counter must hold the value TT_W itself without wrapping.
   function automatic int unsigned tt_cnt_w(input int unsigned tt_w);
      return $clog2(tt_w) + 1;
   endfunction

   localparam int unsigned MAX_CNT_W = tt_cnt_w(MAX_TT_W);

   // Table lookup; callers zero-extend narrower tables and indices.
   function automatic logic tt_lookup(input logic [MAX_TT_W-1:0] tt,
                                      input logic [MAX_N_IN-1:0] idx);
      return tt[idx];
   endfunction

endpackage

// File: rtl/tt_delay_pipe.sv
// Fixed-depth valid/data shift pipe with a single global stall.
module tt_delay_pipe #(
   parameter int unsigned DELAY = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic advance,
   input  logic in_valid,
   input  logic in_bit,
   output logic out_valid,
   output logic out_bit,
   output logic empty
);

   logic [DELAY-1:0] valid_q;
   logic [DELAY-1:0] bit_q;

   // Whole pipe shifts on advance and holds otherwise; bubbles carry a zero data bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         bit_q   <= '0;
      end else if (advance) begin
         valid_q[0] <= in_valid;
         bit_q[0]   <= in_valid & in_bit;
         for (int i = 1; i < int'(DELAY); i++) begin
            valid_q[i] <= valid_q[i-1];
            bit_q[i]   <= bit_q[i-1];
         end
      end
   end

   // Last stage drives the output; empty means no stage holds a live result.
   always_comb begin
      out_valid = valid_q[DELAY-1];
      out_bit   = bit_q[DELAY-1];
      empty     = ~|valid_q;
   end

endmodule

// File: rtl/tt_logic_eval.sv
// Run-time reprogrammable N_IN-input boolean function with a DELAY-cycle output pipe.
// A reload first drains the pipe so no result ever mixes old and new tables.
module tt_logic_eval
   import tt_logic_pkg::*;
#(
   parameter int unsigned     N_IN       = 4,
   parameter int unsigned     TT_W       = 2 ** N_IN,
   parameter int unsigned     DELAY      = 3,
   parameter logic [TT_W-1:0] DEFAULT_TT = TT_W'(16'h41A2)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_start,
   input  logic            cfg_valid,
   input  logic            cfg_bit,
   output logic            cfg_ready,
   output logic            cfg_done,
   input  logic            in_valid,
   input  logic [N_IN-1:0] in_vec,
   output logic            in_ready,
   output logic            out_valid,
   output logic            out_bit,
   input  logic            out_ready
);

   localparam int unsigned      CNT_W    = tt_cnt_w(TT_W);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TT_W - 1);

   tt_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TT_W-1:0]  shadow_q, shadow_d;
   logic [TT_W-1:0]  active_tt_q, active_tt_d;
   logic             done_q, done_d;

   logic             advance;
   logic             accept;
   logic             lookup_bit;
   logic             pipe_empty;
   logic             cfg_xfer;
   logic [TT_W-1:0]  shadow_shifted;

   // Handshake glue: the pipe moves whenever its output slot is free or being taken.
   always_comb begin
      advance        = !out_valid || out_ready;
      in_ready       = (state_q == StRun) && advance && !cfg_start;
      accept         = in_valid && in_ready;
      cfg_ready      = (state_q == StLoad);
      cfg_xfer       = cfg_valid && cfg_ready;
      cfg_done       = done_q;
      shadow_shifted = {shadow_q[TT_W-2:0], cfg_bit};
      lookup_bit     = tt_lookup(MAX_TT_W'(active_tt_q), MAX_N_IN'(in_vec));
   end

   tt_delay_pipe #(
      .DELAY (DELAY)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .advance   (advance),
      .in_valid  (accept),
      .in_bit    (lookup_bit),
      .out_valid (out_valid),
      .out_bit   (out_bit),
      .empty     (pipe_empty)
   );

   // Next-state: RUN -> DRAIN on request, DRAIN -> LOAD once empty, LOAD -> RUN on last bit.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shadow_d    = shadow_q;
      active_tt_d = active_tt_q;
      done_d      = 1'b0;
      unique case (state_q)
         StRun: begin
            if (cfg_start) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (pipe_empty) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            if (cfg_xfer) begin
               shadow_d = shadow_shifted;
               if (cnt_q == LAST_IDX) begin
                  // Commit the full table including the bit arriving now.
                  active_tt_d = shadow_shifted;
                  cnt_d       = '0;
                  done_d      = 1'b1;
                  state_d     = StRun;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = StRun;
         end
      endcase
   end

   // State, table and counter registers; reset discards any partial load.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         cnt_q       <= '0;
         shadow_q    <= '0;
         active_tt_q <= DEFAULT_TT;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shadow_q    <= shadow_d;
         active_tt_q <= active_tt_d;
         done_q      <= done_d;
      end
   end

   // Stalled results must hold still.
   a_stall_stable: assert property (@(posedge clk) disable iff (rst)
      out_valid && !out_ready |=> $stable(out_valid) && $stable(out_bit));

   // A commit always lands back in RUN.
   a_done_in_run: assert property (@(posedge clk) disable iff (rst)
      cfg_done |-> state_q == StRun);

   // Accepted vectors index the table and must be fully known.
   a_vec_known: assert property (@(posedge clk) disable iff (rst)
      in_valid && in_ready |-> !$isunknown(in_vec));

endmodule

// File: tb/tb_tt_logic_eval.sv
// Self-checking bench: directed table, multi-cycle reload sequences and random traffic
// against a queue-based reference model.
module tb_tt_logic_eval;

   localparam int          DELAY  = 3;
   localparam logic [15:0] DEF_TT = 16'h41A2;
   localparam int          MRun   = 0;
   localparam int          MDrain = 1;
   localparam int          MLoad  = 2;

   logic clk;
   logic rst;
   logic cfg_start, cfg_valid, cfg_bit, cfg_ready, cfg_done;
   logic in_valid, in_ready, out_valid, out_bit, out_ready;
   logic [3:0] in_vec;

   logic x_cfg_start, x_cfg_valid, x_cfg_bit, x_cfg_ready, x_cfg_done;
   logic x_in_valid, x_in_ready, x_out_valid, x_out_bit, x_out_ready;
   logic [1:0] x_in_vec;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   tt_logic_eval #(
      .N_IN       (4),
      .DELAY      (3),
      .DEFAULT_TT (16'h41A2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_bit   (cfg_bit),
      .cfg_ready (cfg_ready),
      .cfg_done  (cfg_done),
      .in_valid  (in_valid),
      .in_vec    (in_vec),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_bit   (out_bit),
      .out_ready (out_ready)
   );

   tt_logic_eval #(
      .N_IN       (2),
      .DELAY      (1),
      .DEFAULT_TT (4'b0110)
   ) xdut (
      .clk       (clk),
      .rst       (rst),
      .cfg_start (x_cfg_start),
      .cfg_valid (x_cfg_valid),
      .cfg_bit   (x_cfg_bit),
      .cfg_ready (x_cfg_ready),
      .cfg_done  (x_cfg_done),
      .in_valid  (x_in_valid),
      .in_vec    (x_in_vec),
      .in_ready  (x_in_ready),
      .out_valid (x_out_valid),
      .out_bit   (x_out_bit),
      .out_ready (x_out_ready)
   );

   // Reference model: results in flight are a queue; "virtual time" ticks only when the
   // pipe moves, so an item is visible at the output once its due time is reached.
   typedef struct {
      logic b;
      int   due;
      int   acc_cyc;
   } item_t;

   typedef struct {
      logic [3:0] vec;
      logic       exp;
   } vec_rec_t;

   item_t       sb[$];
   int          vt;
   int          cyc;
   int          mode;
   int          cnt;
   logic [15:0] m_tt;
   logic [15:0] shadow;
   logic        done_pend;
   logic        lat_chk;
   logic        use_tbl;
   logic        tbl_exp;
   int          compared;
   int          failed;
   vec_rec_t    tbl[10];

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic tt_bit(input logic [15:0] tt, input int idx);
      logic [15:0] s;
      s = tt >> idx;
      return s[0];
   endfunction

   task automatic check(input string name, input logic act, input logic exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
      end
   endtask

   // One clock cycle: inputs already driven; sample, compare, update model, clock.
   task automatic step();
      logic m_ov, adv, exp_rdy, was_empty;
      logic done_nxt;
      #2;
      m_ov    = (sb.size() > 0) && (sb[0].due == vt);
      adv     = !m_ov || out_ready;
      exp_rdy = (mode == MRun) && adv && !cfg_start;
      check("out_valid", out_valid, m_ov);
      if (m_ov) check("out_bit", out_bit, sb[0].b);
      check("in_ready", in_ready, exp_rdy);
      check("cfg_ready", cfg_ready, mode == MLoad);
      check("cfg_done", cfg_done, done_pend);
      was_empty = (sb.size() == 0);
      if (m_ov && out_ready) begin
         if (lat_chk) check_int("latency", cyc - sb[0].acc_cyc, DELAY);
         void'(sb.pop_front());
      end
      if (in_valid && exp_rdy)
         sb.push_back('{b: (use_tbl ? tbl_exp : tt_bit(m_tt, int'(in_vec))),
                        due: vt + DELAY, acc_cyc: cyc});
      done_nxt = 1'b0;
      if (mode == MRun) begin
         if (cfg_start) mode = MDrain;
      end else if (mode == MDrain) begin
         if (was_empty) mode = MLoad;
      end else if (cfg_valid) begin
         shadow = {shadow[14:0], cfg_bit};
         cnt++;
         if (cnt == 16) begin
            m_tt     = shadow;
            cnt      = 0;
            mode     = MRun;
            done_nxt = 1'b1;
         end
      end
      done_pend = done_nxt;
      if (adv) vt++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
      cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
      x_in_valid = 1'b0; x_in_vec = '0; x_out_ready = 1'b1;
      x_cfg_start = 1'b0; x_cfg_valid = 1'b0; x_cfg_bit = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete(); vt = 0; mode = MRun; cnt = 0; m_tt = DEF_TT; shadow = '0;
      done_pend = 1'b0;
      #2;
      check("rst_out_bit", out_bit, 1'b0);
      check("rst_x_out_valid", x_out_valid, 1'b0);
      check("rst_x_cfg_ready", x_cfg_ready, 1'b0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; out_ready = 1'b1;
      while (sb.size() > 0 && n < 40) begin
         step();
         n++;
      end
      check_int("drain_left", sb.size(), 0);
   endtask

   task automatic request_load();
      int n;
      n = 0;
      in_valid = 1'b0; cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      while (mode != MLoad && n < 40) begin
         step();
         n++;
      end
      if (mode != MLoad) begin
         compared++;
         failed++;
         $display("FAIL load_wait cyc=%0d got=timeout want=LOAD", cyc);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d got=hang want=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] pat;
      logic        xtbl[4];
      compared = 0; failed = 0; lat_chk = 1'b0; use_tbl = 1'b0; tbl_exp = 1'b0;
      tbl[0] = '{4'd0,  1'b0}; tbl[1] = '{4'd1,  1'b1}; tbl[2] = '{4'd5,  1'b1};
      tbl[3] = '{4'd14, 1'b1}; tbl[4] = '{4'd15, 1'b0}; tbl[5] = '{4'd2,  1'b0};
      tbl[6] = '{4'd4,  1'b0}; tbl[7] = '{4'd7,  1'b1}; tbl[8] = '{4'd8,  1'b1};
      tbl[9] = '{4'd12, 1'b0};
      xtbl = '{1'b0, 1'b1, 1'b1, 1'b0};

      // Back-to-back vectors on the default table, fixed latency.
      do_reset();
      lat_chk = 1'b1; use_tbl = 1'b1;
      foreach (tbl[i]) begin
         in_valid = 1'b1; in_vec = tbl[i].vec; tbl_exp = tbl[i].exp;
         step();
      end
      use_tbl = 1'b0;
      drain();
      lat_chk = 1'b0;

      // Downstream stall of four cycles mid-stream.
      for (int i = 0; i < 14; i++) begin
         in_valid = 1'b1; in_vec = 4'(i + 3);
         out_ready = !(i >= 5 && i < 9);
         step();
      end
      drain();

      // Reload with two results in flight, new table all ones.
      in_valid = 1'b1; in_vec = 4'd1; step();
      in_vec = 4'd5; step();
      request_load();
      for (int i = 0; i < 16; i++) begin
         cfg_valid = 1'b1; cfg_bit = 1'b1;
         step();
      end
      cfg_valid = 1'b0; step();
      in_valid = 1'b1; in_vec = 4'd0; step();
      drain();

      // Reset part-way through a load.
      request_load();
      for (int i = 0; i < 7; i++) begin
         cfg_valid = 1'b1; cfg_bit = 1'(i);
         step();
      end
      do_reset();
      cfg_valid = 1'b1; in_valid = 1'b1; in_vec = 4'd1; step();
      in_valid = 1'b0; step(); step();
      drain();

      // Gapped config stream, then sweep every index of the new table.
      request_load();
      pat = 16'h5A3C;
      for (int i = 15; i >= 0; i--) begin
         cfg_valid = 1'b1; cfg_bit = pat[i];
         step();
         for (int g = 0; g < 3; g++) begin
            cfg_valid = 1'b0; cfg_bit = 1'($urandom);
            step();
         end
      end
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_vec = 4'(i);
         step();
      end
      drain();

      // Two-input XOR instance, single-stage pipe.
      x_out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         x_in_valid = (i < 4); x_in_vec = 2'(i);
         #2;
         if (i < 4) check("x_in_ready", x_in_ready, 1'b1);
         check("x_out_valid", x_out_valid, i > 0);
         if (i > 0) check("x_out_bit", x_out_bit, xtbl[i-1]);
         @(posedge clk);
         #1;
      end
      x_in_valid = 1'b0;

      // Random traffic including random reloads.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom % 10) < 7;
         in_vec    = 4'($urandom);
         out_ready = ($urandom % 4) != 0;
         cfg_start = ($urandom % 40) == 0;
         cfg_valid = 1'($urandom);
         cfg_bit   = 1'($urandom);
         step();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
